// File: rtl/dram_burst_pkg.sv
// Shared types and helpers for the burst DRAM: FSM encoding, latency limits
// and burst-length clamping.
package dram_burst_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RLAT   = 2'd1,
    S_RBURST = 2'd2,
    S_WBURST = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;
  localparam int LAT_W      = $clog2(RD_LAT_MAX);

  // Zero-length bursts move one beat; oversize requests saturate at max_len.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 32'd0) begin
      return 32'd1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/dram_array.sv
// DEPTH x DW single-port synchronous RAM, one-cycle read, write-first.
// Contents are never reset; only the read register is.
module dram_array #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_r;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register holds its value between read enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      rdata_r <= we ? wdata : mem[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dram_burst.sv
// Burst DRAM front end: Ready/Valid/Done handshake, programmable read latency,
// wrapping burst addressing over a dram_array.
module dram_burst
  import dram_burst_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                         Clk1,
  input  logic                         Reset,
  input  logic [AW-1:0]                Addr,
  input  logic                         RD,
  input  logic                         WR,
  input  logic [$clog2(MAX_BURST):0]   BurstLen,
  input  logic [DW-1:0]                DataIn,
  output logic [DW-1:0]                DataOut,
  output logic                         Valid,
  output logic                         Ready,
  output logic                         Done,
  output logic                         Err
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = $clog2(MAX_BURST) + 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  state_t          state_r, state_n;
  logic [IW-1:0]   addr_r, addr_n, mem_addr_s, req_addr_s;
  logic [LW-1:0]   rem_r, rem_n, req_len_s;
  logic [LAT_W-1:0] lat_r, lat_n;
  logic            issue_s, write_s, err_set_s, done_set_s;
  logic            valid_r, done_r, ready_r, err_r;
  logic            unused_s;

  assign req_addr_s = Addr[IW-1:0];
  assign req_len_s  = LW'(clamp_len(32'(BurstLen), 32'(MAX_BURST)));
  assign unused_s   = ^Addr[AW-1:IW];

  // Next-state logic; rem counts beats still to be issued to the array.
  always_comb begin
    state_n    = state_r;
    addr_n     = addr_r;
    rem_n      = rem_r;
    lat_n      = lat_r;
    mem_addr_s = addr_r;
    issue_s    = 1'b0;
    write_s    = 1'b0;
    err_set_s  = 1'b0;
    done_set_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (RD && WR) begin
          err_set_s = 1'b1;
        end else if (RD) begin
          if (RD_LAT == 1) begin
            issue_s    = 1'b1;
            mem_addr_s = req_addr_s;
            addr_n     = req_addr_s + IW'(1);
            rem_n      = req_len_s - LW'(1);
            done_set_s = (req_len_s == LW'(1));
            state_n    = S_RBURST;
          end else begin
            addr_n  = req_addr_s;
            rem_n   = req_len_s;
            lat_n   = LAT_INIT;
            state_n = S_RLAT;
          end
        end else if (WR) begin
          write_s    = 1'b1;
          mem_addr_s = req_addr_s;
          addr_n     = req_addr_s + IW'(1);
          rem_n      = req_len_s - LW'(1);
          if (req_len_s == LW'(1)) begin
            done_set_s = 1'b1;
          end else begin
            state_n = S_WBURST;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RLAT: begin
        if (lat_r == LAT_W'(0)) begin
          issue_s    = 1'b1;
          addr_n     = addr_r + IW'(1);
          rem_n      = rem_r - LW'(1);
          done_set_s = (rem_r == LW'(1));
          state_n    = S_RBURST;
        end else begin
          lat_n = lat_r - LAT_W'(1);
        end
      end
      S_RBURST: begin
        // Stay one extra cycle after the last issue so Ready rises after the last beat.
        if (rem_r != LW'(0)) begin
          issue_s    = 1'b1;
          addr_n     = addr_r + IW'(1);
          rem_n      = rem_r - LW'(1);
          done_set_s = (rem_r == LW'(1));
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WBURST: begin
        write_s = 1'b1;
        addr_n  = addr_r + IW'(1);
        rem_n   = rem_r - LW'(1);
        if (rem_r == LW'(1)) begin
          done_set_s = 1'b1;
          state_n    = S_IDLE;
        end else begin
          state_n = S_WBURST;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      state_r <= S_IDLE;
      addr_r  <= {IW{1'b0}};
      rem_r   <= {LW{1'b0}};
      lat_r   <= {LAT_W{1'b0}};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      addr_r  <= addr_n;
      rem_r   <= rem_n;
      lat_r   <= lat_n;
      valid_r <= issue_s;
      done_r  <= done_set_s;
      ready_r <= (state_n == S_IDLE);
      err_r   <= err_r | err_set_s;
    end
  end

  dram_array #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (Clk1),
    .rst   (Reset),
    .we    (write_s),
    .re    (issue_s),
    .addr  (mem_addr_s),
    .wdata (DataIn),
    .rdata (DataOut)
  );

  assign Valid = valid_r;
  assign Done  = done_r;
  assign Ready = ready_r;
  assign Err   = err_r;

endmodule

// File: tb/tb_dram_burst.sv
// Directed bench for dram_burst: one instance at RD_LAT=2, one at RD_LAT=1,
// sharing address/length/data inputs with separate request strobes.
module tb_dram_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [4:0]  blen;
  logic [15:0] din;
  logic        rd0, wr0, rd1, wr1;
  logic [15:0] dout0, dout1;
  logic        valid0, ready0, done0, err0;
  logic        valid1, ready1, done1, err1;

  int checks = 0;
  int errors = 0;

  logic [15:0] wd [16];
  logic [15:0] ex [16];

  always #5 clk = ~clk;

  dram_burst #(.RD_LAT(2)) u_dut0 (
    .Clk1(clk), .Reset(rst), .Addr(addr), .RD(rd0), .WR(wr0), .BurstLen(blen),
    .DataIn(din), .DataOut(dout0), .Valid(valid0), .Ready(ready0), .Done(done0), .Err(err0)
  );

  dram_burst #(.RD_LAT(1)) u_dut1 (
    .Clk1(clk), .Reset(rst), .Addr(addr), .RD(rd1), .WR(wr1), .BurstLen(blen),
    .DataIn(din), .DataOut(dout1), .Valid(valid1), .Ready(ready1), .Done(done1), .Err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic o_valid(input bit s); return s ? valid1 : valid0; endfunction
  function automatic logic o_ready(input bit s); return s ? ready1 : ready0; endfunction
  function automatic logic o_done(input bit s);  return s ? done1  : done0;  endfunction
  function automatic logic [15:0] o_data(input bit s); return s ? dout1 : dout0; endfunction

  task automatic do_write(input bit s, input logic [15:0] a, input int n, input logic [15:0] d [16]);
    addr = a; blen = 5'(n); din = d[0];
    if (s) wr1 = 1'b1; else wr0 = 1'b1;
    tick;
    wr0 = 1'b0; wr1 = 1'b0;
    for (int i = 1; i < n; i++) begin
      check("wburst_ready", 32'(o_ready(s)), 32'd0);
      din = d[i];
      tick;
    end
    check("wr_done", 32'(o_done(s)), 32'd1);
    check("wr_ready", 32'(o_ready(s)), 32'd1);
  endtask

  task automatic do_read(input bit s, input logic [15:0] a, input int len_in, input int n,
                         input int lat, input logic [15:0] d [16]);
    addr = a; blen = 5'(len_in);
    if (s) rd1 = 1'b1; else rd0 = 1'b1;
    tick;
    rd0 = 1'b0; rd1 = 1'b0;
    for (int j = 1; j < lat; j++) begin
      check("rlat_valid", 32'(o_valid(s)), 32'd0);
      check("rlat_ready", 32'(o_ready(s)), 32'd0);
      tick;
    end
    for (int i = 0; i < n; i++) begin
      check("rd_valid", 32'(o_valid(s)), 32'd1);
      check("rd_data", 32'(o_data(s)), 32'(d[i]));
      check("rd_done", 32'(o_done(s)), (i == n - 1) ? 32'd1 : 32'd0);
      check("rd_ready", 32'(o_ready(s)), 32'd0);
      tick;
    end
    check("rd_end_ready", 32'(o_ready(s)), 32'd1);
    check("rd_end_valid", 32'(o_valid(s)), 32'd0);
    check("rd_end_done", 32'(o_done(s)), 32'd0);
    check("rd_hold_data", 32'(o_data(s)), 32'(d[n - 1]));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; addr = 16'h0000; blen = 5'd0; din = 16'h0000;
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    for (int i = 0; i < 16; i++) begin wd[i] = 16'h0000; ex[i] = 16'h0000; end

    // 1: reset values during and after reset
    tick;
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_dout", 32'(dout0), 32'h0000);
    rst = 1'b0;
    tick;
    check("post_rst_ready", 32'(ready0), 32'd1);
    check("post_rst_valid", 32'(valid0), 32'd0);
    check("post_rst_dout", 32'(dout0), 32'h0000);

    // 2: write len4 then read back, read accepted in the write's Done cycle
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
    do_write(1'b0, 16'h0010, 4, wd);
    do_read(1'b0, 16'h0010, 4, 4, 2, wd);

    // 3: wrap at DEPTH-1 and address aliasing
    wd[0] = 16'hAAAA; wd[1] = 16'hBBBB;
    do_write(1'b0, 16'h03FF, 2, wd);
    ex[0] = 16'hBBBB;
    do_read(1'b0, 16'h0000, 1, 1, 2, ex);
    ex[0] = 16'hAAAA;
    do_read(1'b0, 16'h03FF, 1, 1, 2, ex);
    ex[0] = 16'h1111;
    do_read(1'b0, 16'h0410, 1, 1, 2, ex);

    // 4: simultaneous RD and WR is an error, nothing written
    addr = 16'h0010; blen = 5'd1; din = 16'hDEAD; rd0 = 1'b1; wr0 = 1'b1;
    tick;
    rd0 = 1'b0; wr0 = 1'b0;
    check("rdwr_err", 32'(err0), 32'd1);
    check("rdwr_ready", 32'(ready0), 32'd1);
    check("rdwr_valid", 32'(valid0), 32'd0);
    ex[0] = 16'h1111;
    do_read(1'b0, 16'h0010, 1, 1, 2, ex);
    check("err_sticky", 32'(err0), 32'd1);

    // 5: reset in the middle of a len8 read
    for (int i = 0; i < 8; i++) wd[i] = 16'h0800 + 16'(i);
    do_write(1'b0, 16'h0020, 8, wd);
    addr = 16'h0020; blen = 5'd8; rd0 = 1'b1;
    tick;
    rd0 = 1'b0;
    tick; tick; tick;
    check("mid_valid", 32'(valid0), 32'd1);
    check("mid_data", 32'(dout0), 32'h0802);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", 32'(valid0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    check("abort_ready", 32'(ready0), 32'd1);
    check("abort_dout", 32'(dout0), 32'h0000);
    check("abort_err", 32'(err0), 32'd0);
    tick;
    rst = 1'b0;
    tick;
    check("after_abort_ready", 32'(ready0), 32'd1);
    check("after_abort_valid", 32'(valid0), 32'd0);
    do_read(1'b0, 16'h0020, 2, 2, 2, wd);

    // 6: RD_LAT=1 instance, BurstLen 0 -> 1 beat, 31 -> clamped to 16
    for (int i = 0; i < 16; i++) wd[i] = 16'h5000 + 16'(i);
    do_write(1'b1, 16'h0100, 16, wd);
    do_read(1'b1, 16'h0100, 0, 1, 1, wd);
    do_read(1'b1, 16'h0100, 31, 16, 1, wd);
    check("lat1_err", 32'(err1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
